// File: rtl/alu_div_sequencer_pkg.sv
// Shared constants for the divider sequencer: external ALU opcodes and the
// FSM state encoding.
package alu_div_sequencer_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ITER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_div_sequencer_div_step_mux.sv
// One restoring-division step: forms the shifted partial remainder and selects
// the next remainder/quotient from the ALU subtract result.
module div_step_mux #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] s,
  output logic             take,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic msb;

  always_comb begin
    s      = {r[WIDTH-2:0], q[WIDTH-1]};
    msb    = r[WIDTH-1];
    // A set bit shifted out of R means the true value is >= 2^WIDTH, hence > D,
    // even though the ALU only sees the low WIDTH bits and may report a borrow.
    take   = alu_cout | msb;
    r_next = take ? alu_result : s;
    q_next = {q[WIDTH-2:0], take};
  end

endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle unsigned restoring divider that borrows an external combinational
// ALU for its compare/subtract work, one ALU operation per cycle.
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a response, once valid, holds its payload until it transfers.
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_div_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output state_t           dbg_state
);

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] dreg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] step_s;
  logic             step_take;
  logic [WIDTH-1:0] step_r_next;
  logic [WIDTH-1:0] step_q_next;
  logic             last_iter;

  div_step_mux #(.WIDTH(WIDTH)) u_step (
    .r          (r_reg),
    .q          (q_reg),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .s          (step_s),
    .take       (step_take),
    .r_next     (step_r_next),
    .q_next     (step_q_next)
  );

  assign req_ready = (state == ST_IDLE);
  assign dbg_state = state;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // ALU operands come straight from state and registers so the ALU result is
  // usable in the same cycle; outside CHECK/ITER the ALU is held quiet.
  always_comb begin
    alu_op = ALU_AND;
    alu_a  = '0;
    alu_b  = '0;
    case (state)
      ST_CHECK: begin
        alu_op = ALU_OR;
        alu_a  = dreg;
      end
      ST_ITER: begin
        alu_op = ALU_SUB;
        alu_a  = step_s;
        alu_b  = dreg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      q_reg         <= '0;
      r_reg         <= '0;
      dreg          <= '0;
      cnt           <= '0;
      rsp_valid     <= 1'b0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_div_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            q_reg <= req_dividend;
            dreg  <= req_divisor;
            r_reg <= '0;
            cnt   <= '0;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (alu_zero) begin
            // Q still holds the dividend here, so it becomes the remainder.
            rsp_quotient  <= '1;
            rsp_remainder <= q_reg;
            rsp_div_zero  <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= ST_DONE;
          end else begin
            state <= ST_ITER;
          end
        end
        ST_ITER: begin
          r_reg <= step_r_next;
          q_reg <= step_q_next;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            rsp_quotient  <= step_q_next;
            rsp_remainder <= step_r_next;
            rsp_div_zero  <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer with a 16-bit ALU made of four 4-bit
// carry-lookahead slices standing in for the external datapath ALU.
module tb_alu_div_sequencer;
  import alu_div_sequencer_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_dividend = '0;
  logic [W-1:0] req_divisor = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_quotient;
  logic [W-1:0] rsp_remainder;
  logic         rsp_div_zero;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         alu_zero;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_div_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_div_zero  (rsp_div_zero),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_cout      (alu_cout),
    .alu_zero      (alu_zero),
    .dbg_state     (dbg_state)
  );

  // ---------------- external ALU: four 4-bit CLA slices ----------------
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g, p;
    logic [4:0] c;
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  always_comb begin
    logic [W-1:0] b_eff;
    logic [W-1:0] sum;
    logic         carry;
    logic [4:0]   sl;
    b_eff = alu_op[2] ? ~alu_b : alu_b;
    carry = alu_op[2];
    sum   = '0;
    for (int i = 0; i < W / 4; i++) begin
      sl = cla4(alu_a[i*4 +: 4], b_eff[i*4 +: 4], carry);
      sum[i*4 +: 4] = sl[3:0];
      carry = sl[4];
    end
    alu_cout = carry;
    case (alu_op[1:0])
      2'b00:   alu_result = alu_a & b_eff;
      2'b01:   alu_result = alu_a | b_eff;
      2'b10:   alu_result = sum;
      default: alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
    endcase
    alu_zero = (alu_result == '0);
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_req(input logic [W-1:0] n, input logic [W-1:0] d);
    req_dividend = n;
    req_divisor  = d;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  // Cycle 0 is the request cycle; returns the cycle in which rsp_valid is seen.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if ({rsp_quotient, rsp_remainder, rsp_div_zero} !== '0) begin errors++;
      $display("FAIL reset_rsp_regs got q=%h r=%h z=%b want 0", rsp_quotient, rsp_remainder, rsp_div_zero); end
    checks++; if ({alu_a, alu_b, alu_op} !== '0) begin errors++;
      $display("FAIL reset_alu got a=%h b=%h op=%b want 0", alu_a, alu_b, alu_op); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc;
    send_req(16'd100, 16'd7);
    wait_rsp(cyc);
    checks++; if (cyc != 18) begin errors++; $display("FAIL basic_latency got %0d want 18", cyc); end
    checks++; if (rsp_quotient !== 16'd14) begin errors++; $display("FAIL basic_q got %0d want 14", rsp_quotient); end
    checks++; if (rsp_remainder !== 16'd2) begin errors++; $display("FAIL basic_r got %0d want 2", rsp_remainder); end
    checks++; if (rsp_div_zero !== 1'b0) begin errors++; $display("FAIL basic_dz got %b want 0", rsp_div_zero); end
    take_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL basic_return_idle got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_all_ones();
    int cyc;
    int iters;
    send_req(16'hFFFF, 16'h0001);
    cyc = 1;
    iters = 0;
    while (!rsp_valid && cyc < 60) begin
      if (dbg_state == ST_ITER) begin
        iters++;
        checks++; if (alu_op !== 3'b110 || alu_b !== 16'h0001) begin errors++;
          $display("FAIL iter_alu_op cycle %0d got op=%b b=%h want 110/0001", cyc, alu_op, alu_b); end
      end else if (dbg_state == ST_CHECK) begin
        checks++; if (alu_op !== 3'b001 || alu_a !== 16'h0001 || alu_b !== 16'h0000) begin errors++;
          $display("FAIL check_alu got op=%b a=%h b=%h want 001/0001/0000", alu_op, alu_a, alu_b); end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (iters != 16) begin errors++; $display("FAIL iter_count got %0d want 16", iters); end
    checks++; if (cyc != 18) begin errors++; $display("FAIL ones_latency got %0d want 18", cyc); end
    checks++; if (rsp_quotient !== 16'hFFFF || rsp_remainder !== 16'h0000) begin errors++;
      $display("FAIL ones_result got q=%h r=%h want FFFF/0000", rsp_quotient, rsp_remainder); end
    checks++; if (alu_op !== 3'b000 || alu_a !== '0 || alu_b !== '0) begin errors++;
      $display("FAIL done_alu_quiet got op=%b a=%h b=%h want 0", alu_op, alu_a, alu_b); end
    take_rsp();
  endtask

  task automatic test_div_zero();
    int cyc;
    send_req(16'h1234, 16'h0000);
    wait_rsp(cyc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL dz_latency got %0d want 2", cyc); end
    checks++; if (rsp_quotient !== 16'hFFFF || rsp_remainder !== 16'h1234) begin errors++;
      $display("FAIL dz_result got q=%h r=%h want FFFF/1234", rsp_quotient, rsp_remainder); end
    checks++; if (rsp_div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", rsp_div_zero); end
    take_rsp();
  endtask

  task automatic test_msb_take();
    int cyc;
    send_req(16'h8000, 16'hFFFF);
    wait_rsp(cyc);
    checks++; if (rsp_quotient !== 16'h0000 || rsp_remainder !== 16'h8000) begin errors++;
      $display("FAIL big_divisor got q=%h r=%h want 0000/8000", rsp_quotient, rsp_remainder); end
    take_rsp();
    send_req(16'hFFFE, 16'h8001);
    wait_rsp(cyc);
    checks++; if (rsp_quotient !== 16'h0001 || rsp_remainder !== 16'h7FFD) begin errors++;
      $display("FAIL msb_take got q=%h r=%h want 0001/7FFD", rsp_quotient, rsp_remainder); end
    checks++; if (rsp_div_zero !== 1'b0) begin errors++; $display("FAIL msb_take_dz got %b want 0", rsp_div_zero); end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int cyc;
    send_req(16'd1000, 16'd10);
    wait_rsp(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_quotient !== 16'd100 || rsp_remainder !== 16'd0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b q=%0d r=%0d rdy=%b want 1/100/0/0",
                 i, rsp_valid, rsp_quotient, rsp_remainder, req_ready);
      end
      @(posedge clk); #1;
    end
    // Request offered in the same cycle as the response handshake.
    req_dividend = 16'd9;
    req_divisor  = 16'd3;
    req_valid    = 1'b1;
    rsp_ready    = 1'b1;
    @(posedge clk); #1;
    rsp_ready    = 1'b0;
    checks++; if (dbg_state !== ST_IDLE || req_ready !== 1'b1) begin errors++;
      $display("FAIL no_overlap got state=%0d ready=%b want 0/1", dbg_state, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(cyc);
    checks++; if (cyc != 18) begin errors++; $display("FAIL b2b_latency got %0d want 18", cyc); end
    checks++; if (rsp_quotient !== 16'd3 || rsp_remainder !== 16'd0) begin errors++;
      $display("FAIL b2b_result got q=%0d r=%0d want 3/0", rsp_quotient, rsp_remainder); end
    take_rsp();
  endtask

  task automatic test_mid_reset();
    int cyc;
    int iters;
    int guard;
    send_req(16'h4321, 16'd3);
    iters = 0;
    guard = 0;
    while (iters < 8 && guard < 40) begin
      if (dbg_state == ST_ITER) iters++;
      if (iters < 8) begin
        @(posedge clk); #1;
      end
      guard++;
    end
    checks++; if (iters != 8) begin errors++; $display("FAIL reach_iter8 got %0d want 8", iters); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (dbg_state !== ST_IDLE || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL async_reset_ctrl got state=%0d ready=%b valid=%b want 0/1/0", dbg_state, req_ready, rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_op} !== '0 || {rsp_quotient, rsp_remainder, rsp_div_zero} !== '0) begin errors++;
      $display("FAIL async_reset_data got a=%h b=%h op=%b q=%h r=%h want 0", alu_a, alu_b, alu_op, rsp_quotient, rsp_remainder); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL aborted_rsp cycle %0d got valid=1 want 0", i); end
      @(posedge clk); #1;
    end
    send_req(16'd50, 16'd5);
    wait_rsp(cyc);
    checks++; if (cyc != 18) begin errors++; $display("FAIL post_reset_latency got %0d want 18", cyc); end
    checks++; if (rsp_quotient !== 16'd10 || rsp_remainder !== 16'd0) begin errors++;
      $display("FAIL post_reset_result got q=%0d r=%0d want 10/0", rsp_quotient, rsp_remainder); end
    take_rsp();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_div_zero();
    test_msb_take();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
